pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL take `DUTY_CYCLE_WIDTH, `COUNTER_WIDTH, `MAX_COUNTER, `DEAD_TIME and `DUTY_CYCLE_STEP_RES from phase_driver.vh, where `DUTY_CYCLE_STEP_RES is a power of two.
REQ-002 Parameter: TIMEOUT_CYCLES, default 2*`MAX_COUNTER, the idle cycles without a pwm_in edge before a stuck condition is declared.
REQ-003 Parameter: FILTER_LEN, default 3, the number of consecutive equal samples the glitch filter requires.
REQ-004 Port: clock  in  1  sole clock, rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: pwm_in  in  1  asynchronous low-side gate signal from a PWM_LOW-style driver.
REQ-007 Port: duty_cycle  out  `DUTY_CYCLE_WIDTH  last decoded duty value.
REQ-008 Port: duty_valid  out  1  one-cycle strobe when duty_cycle updates.
REQ-009 Port: period  out  `COUNTER_WIDTH  last measured falling-to-falling period, in clocks.
REQ-010 Port: stuck_high / stuck_low  out  1 each  set when pwm_in has held high / low for TIMEOUT_CYCLES.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer, then an edge-detect register.
REQ-012 State machine states are SYNC, MEAS_LOW and MEAS_HIGH; SYNC is entered on reset.
- SYNC -> MEAS_LOW on a falling edge.
- MEAS_LOW -> MEAS_HIGH on a rising edge.
- MEAS_HIGH -> MEAS_LOW on a falling edge.
REQ-013 low_cnt SHALL count clocks in MEAS_LOW; on the rising edge, low_time = low_cnt.
REQ-014 On each rising edge in MEAS_LOW, the block SHALL set duty_cycle = (low_time >> log2(`DUTY_CYCLE_STEP_RES)) - 2*`DEAD_TIME.
- Result is truncated.
- A negative result clamps to 0.
- A result above 2^`DUTY_CYCLE_WIDTH-1 clamps to all-ones.
REQ-015 duty_valid SHALL pulse for one clock, in the cycle after the synchronized rising edge is detected, giving 3 clocks from pwm_in sampled high to duty_valid with the filter disabled.
REQ-016 per_cnt SHALL count from falling edge to falling edge; period SHALL update on each falling edge leaving MEAS_HIGH, saturating at all-ones.
REQ-017 Counters SHALL saturate, never wrap.
REQ-018 No edge for TIMEOUT_CYCLES while high SHALL set stuck_high, force duty_cycle=0, pulse duty_valid once, and return to SYNC.
REQ-019 No edge for TIMEOUT_CYCLES while low SHALL set stuck_low, force duty_cycle to all-ones, pulse duty_valid once, and return to SYNC.
REQ-020 stuck_high and stuck_low SHALL clear on the next detected edge of pwm_in.
REQ-021 The first rising edge after reset or after SYNC SHALL NOT produce duty_valid, because the low interval is incomplete.
REQ-022 If an edge and a timeout occur in the same cycle, the edge SHALL win and the timeout counter restarts.

Reset
REQ-023 On reset_n low, asynchronously:
- state=SYNC
- duty_cycle=0, duty_valid=0, period=0
- stuck_high=0, stuck_low=0
- all counters and synchronizer flops = 0
REQ-024 Reset asserted mid-measurement SHALL discard the partial interval; the first valid output follows a complete low interval.

Configuration
REQ-025 With PWM_CAPTURE_GLITCH_FILTER_EN defined, the synchronized input SHALL change only after FILTER_LEN consecutive equal samples; this adds FILTER_LEN clocks of latency and rejects pulses shorter than FILTER_LEN.
REQ-026 Without PWM_CAPTURE_GLITCH_FILTER_EN, the synchronizer output SHALL feed edge detection directly.

Structure
REQ-027 State encoding and timing constants SHALL live in phase_driver.vh / the shared package; no local redefinition of `DEAD_TIME or `DUTY_CYCLE_STEP_RES.
REQ-028 The synchronizer plus optional filter SHALL be one sub-module, pwm_input_filter; the FSM, counters and decode stay in pwm_capture.

Verification
Bench build values: `MAX_COUNTER=1000, `DEAD_TIME=2, `DUTY_CYCLE_STEP_RES=4, `DUTY_CYCLE_WIDTH=8, filter off.
REQ-029 Steady duty: a PWM_LOW stimulus at duty 100 (low 416, high 584) -> duty_cycle=100, period=1000, and one duty_valid per period from the second rising edge onward.
REQ-030 Clamping: low 10 clocks -> duty_cycle=0; low 2000 clocks with TIMEOUT_CYCLES=4000 -> duty_cycle=255.
REQ-031 Stuck: pwm_in held high 2000 clocks -> stuck_high=1, duty_cycle=0, exactly one duty_valid; the next falling edge clears stuck_high.
REQ-032 Reset mid-measurement: reset_n pulsed at low_cnt=200 -> all outputs 0, no duty_valid until one full low interval has followed.
REQ-033 Filter: with PWM_CAPTURE_GLITCH_FILTER_EN defined, a 2-clock glitch -> no state change; a 3-clock pulse -> edge accepted, and latency is 3 clocks more than with the filter off.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_capture_pkg : phase_driver timing constants, states, decoder   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package pwm_capture_pkg;

  // Project builds supply these from phase_driver.vh; the fallbacks keep
  // the block self-contained when that header is not pulled in first.
`ifndef DUTY_CYCLE_WIDTH
  `define DUTY_CYCLE_WIDTH 8
`endif
`ifndef COUNTER_WIDTH
  `define COUNTER_WIDTH 12
`endif
`ifndef MAX_COUNTER
  `define MAX_COUNTER 1000
`endif
`ifndef DEAD_TIME
  `define DEAD_TIME 2
`endif
`ifndef DUTY_CYCLE_STEP_RES
  `define DUTY_CYCLE_STEP_RES 4
`endif

  localparam int DUTY_CYCLE_WIDTH    = `DUTY_CYCLE_WIDTH;
  localparam int COUNTER_WIDTH       = `COUNTER_WIDTH;
  localparam int MAX_COUNTER         = `MAX_COUNTER;
  localparam int DEAD_TIME           = `DEAD_TIME;
  localparam int DUTY_CYCLE_STEP_RES = `DUTY_CYCLE_STEP_RES;
  localparam int STEP_SHIFT          = $clog2(DUTY_CYCLE_STEP_RES);

  localparam logic [COUNTER_WIDTH-1:0] DEAD_SPAN = COUNTER_WIDTH'(2 * DEAD_TIME);
  localparam logic [COUNTER_WIDTH-1:0] DUTY_FULL = COUNTER_WIDTH'((1 << DUTY_CYCLE_WIDTH) - 1);

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    MEAS_LOW  = 2'd1,
    MEAS_HIGH = 2'd2
  } state_t;

  // Low-time in clocks to duty steps, minus both dead-time bands, clamped.
  function automatic logic [DUTY_CYCLE_WIDTH-1:0] decode_duty(input logic [COUNTER_WIDTH-1:0] low_time);
    logic [COUNTER_WIDTH-1:0] steps;
    logic [COUNTER_WIDTH-1:0] excess;
    steps  = low_time >> STEP_SHIFT;
    excess = steps - DEAD_SPAN;
    if (steps <= DEAD_SPAN) return '0;
    if (excess > DUTY_FULL) return '1;
    return excess[DUTY_CYCLE_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_capture_if : gate input and decoded-duty outputs of the capture |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface pwm_capture_if;
  import pwm_capture_pkg::*;

  logic                          pwm_in;
  logic [DUTY_CYCLE_WIDTH-1:0]   duty_cycle;
  logic                          duty_valid;
  logic [COUNTER_WIDTH-1:0]      period;
  logic                          stuck_high;
  logic                          stuck_low;

  modport master (
    output pwm_in,
    input  duty_cycle, duty_valid, period, stuck_high, stuck_low
  );

  modport slave (
    input  pwm_in,
    output duty_cycle, duty_valid, period, stuck_high, stuck_low
  );
endinterface
`default_nettype wire

// File: rtl/pwm_input_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_input_filter : 2-flop synchronizer, optional glitch filter     |
// | (PWM_CAPTURE_GLITCH_FILTER_EN)  Rev 1.0 - initial release          |
// +--------------------------------------------------------------------+
module pwm_input_filter
  import pwm_capture_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pwm_in,
  output logic pwm_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= pwm_in;
      r_sync <= r_meta;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int c_run_w = $clog2(FILTER_LEN + 1);

  logic [c_run_w-1:0] r_run;
  logic               r_filt;

  // r_run counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync == r_filt) begin
      r_run  <= '0;
    end else if (r_run == c_run_w'(FILTER_LEN - 1)) begin
      r_run  <= '0;
      r_filt <= r_sync;
    end else begin
      r_run  <= r_run + 1'b1;
    end
  end

  assign pwm_sync = r_filt;
`else
  assign pwm_sync = r_sync;
`endif

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_capture : decodes low-side gate timing into duty, period, stuck |
// | (PWM_CAPTURE_GLITCH_FILTER_EN selects input filter)  Rev 1.0       |
// +--------------------------------------------------------------------+
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2 * MAX_COUNTER,
  parameter int FILTER_LEN     = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  pwm_capture_if.slave  bus
);

  localparam int c_idle_w = $clog2(TIMEOUT_CYCLES + 1);

  logic                         w_level;
  logic                         r_level_d;
  logic                         r_rise;
  logic                         r_fall;
  logic                         w_edge;
  logic                         w_timeout;
  logic [c_idle_w-1:0]          r_idle;
  state_t                       r_state;
  state_t                       w_state_d;
  logic                         w_start_low;
  logic                         w_load_duty;
  logic                         w_load_period;
  logic [COUNTER_WIDTH-1:0]     r_low_cnt;
  logic [COUNTER_WIDTH-1:0]     r_per_cnt;
  logic [COUNTER_WIDTH-1:0]     r_period;
  logic [DUTY_CYCLE_WIDTH-1:0]  r_duty;
  logic                         r_duty_valid;
  logic                         r_stuck_high;
  logic                         r_stuck_low;

  pwm_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .pwm_in   (bus.pwm_in),
    .pwm_sync (w_level)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_rise    <= w_level & ~r_level_d;
      r_fall    <= ~w_level & r_level_d;
    end
  end

  assign w_edge    = r_rise | r_fall;
  // An edge in the same cycle masks the timeout and restarts idle counting.
  assign w_timeout = !w_edge && (r_idle == c_idle_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idle <= '0;
    end else if (w_edge) begin
      r_idle <= '0;
    end else if (r_idle != c_idle_w'(TIMEOUT_CYCLES)) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= SYNC;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d     = r_state;
    w_start_low   = 1'b0;
    w_load_duty   = 1'b0;
    w_load_period = 1'b0;
    if (w_timeout) begin
      w_state_d = SYNC;
    end else begin
      case (r_state)
        SYNC: begin
          if (r_fall) begin
            w_state_d   = MEAS_LOW;
            w_start_low = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (r_rise) begin
            w_state_d   = MEAS_HIGH;
            w_load_duty = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (r_fall) begin
            w_state_d     = MEAS_LOW;
            w_start_low   = 1'b1;
            w_load_period = 1'b1;
          end
        end
        default: w_state_d = SYNC;
      endcase
    end
  end

  // Both counters restart at 1 on the fall so they read the exact interval length.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_low_cnt <= '0;
      r_per_cnt <= '0;
    end else if (w_start_low) begin
      r_low_cnt <= COUNTER_WIDTH'(1);
      r_per_cnt <= COUNTER_WIDTH'(1);
    end else begin
      if (r_state == MEAS_LOW && r_low_cnt != '1) r_low_cnt <= r_low_cnt + 1'b1;
      if (r_state != SYNC && r_per_cnt != '1)     r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_period     <= '0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      if (w_timeout) begin
        r_duty_valid <= 1'b1;
        if (r_level_d) begin
          r_stuck_high <= 1'b1;
          r_duty       <= '0;
        end else begin
          r_stuck_low  <= 1'b1;
          r_duty       <= '1;
        end
      end else begin
        if (w_edge) begin
          r_stuck_high <= 1'b0;
          r_stuck_low  <= 1'b0;
        end
        if (w_load_duty) begin
          r_duty       <= decode_duty(r_low_cnt);
          r_duty_valid <= 1'b1;
        end
        if (w_load_period) r_period <= r_per_cnt;
      end
    end
  end

  assign bus.duty_cycle = r_duty;
  assign bus.duty_valid = r_duty_valid;
  assign bus.period     = r_period;
  assign bus.stuck_high = r_stuck_high;
  assign bus.stuck_low  = r_stuck_low;

endmodule
`default_nettype wire
